// File: rtl/fetch_if.sv
// Fetch front-end bundle: instruction-memory req/ack, decode valid/ready and redirect.
// The fetch unit takes the master side; memory, decode and branch logic take the slave side.
interface fetch_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [ILEN-1:0] imem_rdata;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [CW-1:0]   fifo_count;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc, fifo_count,
        input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, fifo_count,
        output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generator, single-outstanding imem handshake,
// FWFT prefetch FIFO of {pc, inst} pairs and redirect flush of queued/in-flight words.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] PC_STEP  = XLEN'(4)
) (
    input  logic   clk,
    input  logic   reset,
    fetch_if.master io_bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // IDLE: no request, waiting for FIFO space | FETCH: request at fpc | DROP: discard in-flight word
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_req;
    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] w_fpc_next;
    logic [XLEN-1:0] r_pend_pc;
    logic [XLEN-1:0] w_pend_next;

    logic [XLEN-1:0] r_mem_pc   [DEPTH];
    logic [ILEN-1:0] r_mem_inst [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_next;

    logic w_valid;
    logic w_ack;
    logic w_push;
    logic w_pop;
    logic w_space;

    assign w_valid = (r_count != '0);
    assign w_ack   = r_req && io_bus.imem_ack;
    assign w_pop   = w_valid && io_bus.inst_ready && !io_bus.redirect;
    assign w_push  = (r_state == S_FETCH) && w_ack && !io_bus.redirect;

    always_comb begin
        w_count_next = r_count;
        if (io_bus.redirect)
            w_count_next = '0;
        else if (w_push && !w_pop)
            w_count_next = r_count + CW'(1);
        else if (!w_push && w_pop)
            w_count_next = r_count - CW'(1);
    end

    // Room left after this cycle keeps one slot free for the word a new request will return.
    assign w_space = (w_count_next < DEPTH_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_req   <= (w_state_next != S_IDLE);
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fpc_next   = r_fpc;
        w_pend_next  = r_pend_pc;
        unique case (r_state)
            S_IDLE: begin
                if (io_bus.redirect) begin
                    w_fpc_next   = io_bus.redirect_pc;
                    w_state_next = S_FETCH;
                end else if (w_space) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (w_ack) begin
                    if (io_bus.redirect) begin
                        w_fpc_next = io_bus.redirect_pc;
                    end else begin
                        w_fpc_next = r_fpc + PC_STEP;
                        if (!w_space)
                            w_state_next = S_IDLE;
                    end
                end else if (io_bus.redirect) begin
                    w_pend_next  = io_bus.redirect_pc;
                    w_state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (w_ack) begin
                    w_fpc_next   = io_bus.redirect ? io_bus.redirect_pc : r_pend_pc;
                    w_state_next = S_FETCH;
                end else if (io_bus.redirect) begin
                    w_pend_next = io_bus.redirect_pc;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        io_bus.imem_req   = r_req;
        io_bus.imem_addr  = r_req ? r_fpc : '0;
        io_bus.inst_valid = w_valid;
        io_bus.inst_data  = w_valid ? r_mem_inst[r_rptr] : '0;
        io_bus.inst_pc    = w_valid ? r_mem_pc[r_rptr] : '0;
        io_bus.fifo_count = r_count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fpc     <= RESET_PC;
            r_pend_pc <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_fpc     <= w_fpc_next;
            r_pend_pc <= w_pend_next;
            r_count   <= w_count_next;
            if (io_bus.redirect) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + AW'(1);
                if (w_pop)
                    r_rptr <= r_rptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr]   <= r_fpc;
            r_mem_inst[r_wptr] <= io_bus.imem_rdata;
        end
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation (pipelined) RISC datapath.
- Replaces the bare PC register, +4 adder and branch-select path with:
  - a fetch-PC generator,
  - a req/ack instruction-memory handshake that tolerates variable latency,
  - a DEPTH-entry first-word-fall-through prefetch FIFO holding {pc, instruction} pairs,
  - a branch/jump redirect that flushes queued and in-flight fetches.
- Feeds the decode stage through a valid/ready handshake.

Parameters:
XLEN, 32, width of PC and instruction-memory address
ILEN, 32, instruction width
DEPTH, 4, prefetch FIFO entries; power of two, 2..16
RESET_PC, 0, fetch address after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  XLEN  fetch address; stable while imem_req high
imem_ack  input  1  response valid this cycle (only meaningful while imem_req high)
imem_rdata  input  ILEN  instruction word, valid with imem_ack
inst_valid  output  1  FIFO head valid to decode
inst_ready  input  1  decode accepts head
inst_data  output  ILEN  head instruction
inst_pc  output  XLEN  head PC
redirect  input  1  branch taken / jump: flush and refetch
redirect_pc  input  XLEN  new fetch address, valid with redirect
fifo_count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, immediate):
  - state=IDLE, fpc=RESET_PC, pend_pc=0, FIFO pointers/count=0.
  - imem_req=0, inst_valid=0, fifo_count=0; imem_addr/inst_data/inst_pc read 0.
- Memory protocol:
  - imem_req is registered.
  - Response accepted on any rising edge with imem_req && imem_ack; ack in the first cycle req is high is legal.
  - At most one request outstanding.
  - imem_addr and imem_req never change between req rise and ack.
- FIFO:
  - First-word-fall-through: inst_valid = (count != 0); inst_data/inst_pc show the head.
  - Pop on inst_valid && inst_ready. Push on accepted ack in FETCH with no redirect.
  - Push and pop in the same cycle are both legal; count unchanged.
  - Pointers wrap modulo DEPTH.
  - count_next = count after this cycle's push/pop/flush.
  - space = (count_next < DEPTH), which reserves a slot for the in-flight word, so push-when-full is unreachable. Bench asserts this.
- FSM:
  - IDLE (req=0):
    - redirect: fpc<=redirect_pc, flush; go FETCH.
    - else if space: go FETCH.
  - FETCH (req=1, imem_addr=fpc):
    - ack && !redirect: push {fpc, rdata}; fpc<=fpc+PC_STEP (mod 2^XLEN, wraps); stay FETCH if space, else IDLE.
    - ack && redirect: discard rdata, flush, fpc<=redirect_pc; stay FETCH.
    - !ack && redirect: flush, pend_pc<=redirect_pc; go DROP.
    - !ack && !redirect: hold.
  - DROP (req=1, imem_addr=old fpc, response discarded):
    - redirect: pend_pc<=redirect_pc (newest wins); flush again.
    - ack: fpc<=pend_pc, or redirect_pc if redirect is also asserted; go FETCH.
- Priority and flush rules:
  - Redirect overrides pop and push in the same cycle: FIFO count 0 next cycle, inst_valid=0.
  - A pop in the redirect cycle is not counted as consumed.
- Latency:
  - Reset release → imem_req high after first clk edge.
  - Ack at edge N → inst_valid high after edge N, i.e. cycle N+1 if the FIFO was empty.
  - Redirect at edge N in IDLE/FETCH-with-ack → imem_addr=redirect_pc from cycle N+1.
- No deadlock: decode stalled indefinitely with FIFO full → IDLE, req=0; one pop → FETCH next edge.

Test Plan:
- Reset, imem_ack tied 1, inst_ready=1, RESET_PC=0 → imem_addr 0,4,8,… each cycle; inst_pc trails by one cycle; inst_data matches memory model; fifo_count ≤1.
- inst_ready=0, ack always 1, DEPTH=4 → exactly 4 pushes (pc 0,4,8,12), then req=0 in IDLE, fifo_count=4. Release ready one cycle → one pop, req reasserts at pc 16; order preserved.
- Random ack latency 0–5 cycles with random inst_ready → req/addr never change while pending; decode sees pc strictly +4 with no gaps or duplicates over 1000 instructions, including pointer wrap.
- FIFO holding 3 entries, request pending at 0x20, redirect to 0x100 before ack → FIFO empty next cycle; late ack data for 0x20 dropped; next req at 0x100; first inst_pc=0x100.
- Redirect to 0x200 in the same cycle as ack, and a second redirect to 0x300 during DROP → no word from old stream reaches decode; fetch resumes at 0x200, respectively 0x300.
- Assert reset mid-request with FIFO half full → imem_req, inst_valid, fifo_count drop immediately, without a clock; after release, fetch restarts at RESET_PC.
